// File: rtl/vga_timing_gen_if.sv
// Shared VGA raster bus plus the default screen geometry used by the timing generator.
package vga_pkg;
  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
endpackage

interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counter with registered sync/blank decodes, frame strobe and frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::HOR_PIXELS,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = vga_pkg::VER_PIXELS,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int FCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  vga_if.out                vga_out,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_geometry
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 2048");
  end

  localparam logic [10:0] H_MAX      = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX      = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLNK_ON  = 11'(H_ACTIVE);
  localparam logic [10:0] V_BLNK_ON  = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] V_SYNC_ON  = 11'(V_ACTIVE + V_FP);
  // Sync end can equal 2048 when the back porch is empty, so it gets one extra bit.
  localparam logic [11:0] H_SYNC_OFF = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_SYNC_OFF = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_q, v_q, h_nxt, v_nxt;
  logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic        h_wrap, frame_wrap;

  always_comb begin
    h_wrap     = (h_q == H_MAX);
    frame_wrap = h_wrap && (v_q == V_MAX);
    h_nxt      = h_wrap ? 11'd0 : h_q + 11'd1;
    v_nxt      = v_q;
    if (frame_wrap)  v_nxt = 11'd0;
    else if (h_wrap) v_nxt = v_q + 11'd1;
  end

  // Decodes are taken from the next-state counts so they land in the same register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q         <= '0;
      v_q         <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblnk_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      frame_start <= 1'b1;
      frame_cnt   <= '0;
    end else if (en) begin
      h_q         <= h_nxt;
      v_q         <= v_nxt;
      hblnk_q     <= (h_nxt >= H_BLNK_ON);
      vblnk_q     <= (v_nxt >= V_BLNK_ON);
      hsync_q     <= (h_nxt >= H_SYNC_ON) && ({1'b0, h_nxt} < H_SYNC_OFF);
      vsync_q     <= (v_nxt >= V_SYNC_ON) && ({1'b0, v_nxt} < V_SYNC_OFF);
      frame_start <= frame_wrap;
      if (frame_wrap) frame_cnt <= frame_cnt + 1'b1;
    end else begin
      frame_start <= 1'b0;
    end
  end

  assign vga_out.hcount = h_q;
  assign vga_out.vcount = v_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = 12'h000;
endmodule
